// File: rtl/fifo_axis_packer.sv
// fifo_axis_packer: packs upstream FIFO bytes little-endian into 32-bit AXI-Stream words (clk, rst, en, fifo_dout/fifo_empty/fifo_rd_en, m_axis_tdata/tvalid/tready/tlast, pkt_cnt)
module fifo_axis_packer #(
  parameter int PKT_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [7:0]  fifo_dout,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic [15:0] pkt_cnt
);
  logic        rd_vld, slot_free, load;
  logic [2:0]  byte_cnt, held;
  logic [31:0] acc, acc_n;
  logic [15:0] wcnt;
  assign held = byte_cnt + {2'b00, rd_vld};
  assign slot_free = !m_axis_tvalid || m_axis_tready;
  assign load = held == 3'd4 && slot_free;
  assign fifo_rd_en = !rst && en && !fifo_empty && (held < 3'd4 || load);
  always_comb begin
    acc_n = acc;
    if (rd_vld) acc_n[{byte_cnt[1:0], 3'b000} +: 8] = fifo_dout;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld        <= 1'b0;
      byte_cnt      <= 3'd0;
      acc           <= 32'd0;
      wcnt          <= 16'd0;
      m_axis_tdata  <= 32'd0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      pkt_cnt       <= 16'd0;
    end else begin
      rd_vld   <= fifo_rd_en;
      acc      <= acc_n;
      byte_cnt <= load ? 3'd0 : held;
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast) pkt_cnt <= pkt_cnt + 16'd1;
      if (load) begin
        m_axis_tdata  <= acc_n;
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= wcnt == 16'(PKT_WORDS - 1);
        wcnt          <= wcnt == 16'(PKT_WORDS - 1) ? 16'd0 : wcnt + 16'd1;
      end else if (slot_free) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end
endmodule
